// File: rtl/clk_edge_recover_if.sv
// Slow-clock recovery bundle: the external slow clock in, filtered level,
// edge pulses, period measurement and stall flag out.
interface clk_edge_recover_if #(
  parameter int unsigned PW = 16
);
  logic          slowclk;
  logic          level;
  logic          rise;
  logic          fall;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          stalled;

  modport master (
    output slowclk,
    input  level, rise, fall, period, period_valid, stalled
  );

  modport slave (
    input  slowclk,
    output level, rise, fall, period, period_valid, stalled
  );
endinterface

// File: rtl/clk_edge_recover.sv
// Brings an asynchronous slow clock into the sysclk domain: synchronise, debounce,
// emit one-cycle rise/fall enables, measure rise-to-rise period, flag a stopped clock.
module clk_edge_recover #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 4,
  parameter int unsigned TIMEOUT     = 256,
  parameter int unsigned PW          = 16
) (
  input  logic              sysclk,
  input  logic              reset,
  clk_edge_recover_if.slave sc
);

  localparam int unsigned DW = $clog2(DEBOUNCE + 1);
  localparam int unsigned IW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] PMAX = '1;

  typedef enum logic [1:0] {
    ST_NO_REF,
    ST_ONE_REF,
    ST_VALID
  } meas_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DW-1:0]          dcnt_q, dcnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [PW-1:0]          pcnt_q, pcnt_d;
  logic [PW-1:0]          period_q, period_d;
  logic [IW-1:0]          icnt_q, icnt_d;
  logic                   stalled_q, stalled_d;
  meas_e                  state_q, state_d;

  logic s;
  logic toggle;
  logic rise_now;
  logic stall_hit;
  logic period_valid;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      dcnt_q    <= '0;
      level_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      pcnt_q    <= '0;
      period_q  <= '0;
      icnt_q    <= '0;
      stalled_q <= '0;
    end else begin
      sync_q    <= sync_d;
      dcnt_q    <= dcnt_d;
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      pcnt_q    <= pcnt_d;
      period_q  <= period_d;
      icnt_q    <= icnt_d;
      stalled_q <= stalled_d;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) state_q <= ST_NO_REF;
    else       state_q <= state_d;
  end

  // Synchroniser, debounce filter and edge pulse generation
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], sc.slowclk};
    s       = sync_q[SYNC_STAGES-1];
    toggle  = 1'b0;
    dcnt_d  = '0;
    level_d = level_q;
    if (s != level_q) begin
      if (dcnt_q == DW'(DEBOUNCE - 1)) begin
        toggle  = 1'b1;
        level_d = ~level_q;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
    rise_now = toggle & ~level_q;
    rise_d   = rise_now;
    fall_d   = toggle & level_q;
  end

  // Period and idle counters; the stall flag drops in the same cycle as the pulse
  always_comb begin
    pcnt_d = rise_now ? '0 : ((pcnt_q == PMAX) ? pcnt_q : pcnt_q + 1'b1);

    period_d = period_q;
    if (rise_now && (state_q != ST_NO_REF))
      period_d = (pcnt_q == PMAX) ? PMAX : pcnt_q + 1'b1;

    if (toggle)
      icnt_d = '0;
    else if (icnt_q == IW'(TIMEOUT))
      icnt_d = icnt_q;
    else
      icnt_d = icnt_q + 1'b1;

    stall_hit = ~toggle & (icnt_d == IW'(TIMEOUT));

    stalled_d = stalled_q;
    if (toggle)
      stalled_d = 1'b0;
    else if (stall_hit)
      stalled_d = 1'b1;
  end

  // A stall discards the reference rise, so two fresh rises rebuild validity
  always_comb begin
    state_d = state_q;
    if (stall_hit) begin
      state_d = ST_NO_REF;
    end else if (rise_now) begin
      unique case (state_q)
        ST_NO_REF:  state_d = ST_ONE_REF;
        ST_ONE_REF: state_d = ST_VALID;
        ST_VALID:   state_d = ST_VALID;
        default:    state_d = ST_NO_REF;
      endcase
    end
  end

  always_comb begin
    period_valid = (state_q == ST_VALID);
  end

  assign sc.level        = level_q;
  assign sc.rise         = rise_q;
  assign sc.fall         = fall_q;
  assign sc.period       = period_q;
  assign sc.period_valid = period_valid;
  assign sc.stalled      = stalled_q;

endmodule

// File: tb/tb_clk_edge_recover.sv
// Directed bench for clk_edge_recover: default instance plus a PW=8/TIMEOUT=1000
// instance for period saturation.
module tb_clk_edge_recover;

  logic sysclk = 1'b0;
  logic reset;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  clk_edge_recover_if #(.PW(16)) sc1 ();
  clk_edge_recover_if #(.PW(8))  sc2 ();

  clk_edge_recover #(
    .SYNC_STAGES(2), .DEBOUNCE(4), .TIMEOUT(256), .PW(16)
  ) u_dut (
    .sysclk (sysclk),
    .reset  (reset),
    .sc     (sc1)
  );

  clk_edge_recover #(
    .SYNC_STAGES(2), .DEBOUNCE(4), .TIMEOUT(1000), .PW(8)
  ) u_dut8 (
    .sysclk (sysclk),
    .reset  (reset),
    .sc     (sc2)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge sysclk);
  endtask

  initial begin
    reset       = 1'b1;
    sc1.slowclk = 1'b0;
    sc2.slowclk = 1'b0;
    #1;
    chk("rst_level",   32'(sc1.level), 32'd0);
    chk("rst_rise",    32'(sc1.rise), 32'd0);
    chk("rst_fall",    32'(sc1.fall), 32'd0);
    chk("rst_period",  32'(sc1.period), 32'd0);
    chk("rst_pv",      32'(sc1.period_valid), 32'd0);
    chk("rst_stalled", 32'(sc1.stalled), 32'd0);
    chk("rst8_period", 32'(sc2.period), 32'd0);

    // Test 1: idle input, stall exactly 256 cycles after release
    step(2);
    reset = 1'b0;
    for (int unsigned i = 1; i <= 255; i++) begin
      step(1);
      chk("idle_rise", 32'(sc1.rise), 32'd0);
      chk("idle_fall", 32'(sc1.fall), 32'd0);
      chk("idle_stalled", 32'(sc1.stalled), 32'd0);
    end
    chk("idle_level", 32'(sc1.level), 32'd0);
    chk("idle_pv", 32'(sc1.period_valid), 32'd0);
    step(1);
    chk("stall_256", 32'(sc1.stalled), 32'd1);
    step(44);
    chk("stall_300", 32'(sc1.stalled), 32'd1);
    chk("stall_300_level", 32'(sc1.level), 32'd0);

    // Test 2: 8 high / 8 low square wave, pulses 6 cycles after each input edge
    for (int unsigned c = 0; c < 64; c++) begin
      sc1.slowclk = ((c % 16) < 8);
      step(1);
      chk("sq_rise",    32'(sc1.rise), 32'((c % 16) == 5));
      chk("sq_fall",    32'(sc1.fall), 32'((c % 16) == 13));
      chk("sq_level",   32'(sc1.level), 32'(((c % 16) >= 5) && ((c % 16) <= 12)));
      chk("sq_stalled", 32'(sc1.stalled), 32'(c < 5));
      chk("sq_pv",      32'(sc1.period_valid), 32'(c >= 21));
      chk("sq_period",  32'(sc1.period), (c >= 21) ? 32'd16 : 32'd0);
    end

    // Test 4: hold low after the last fall, stall 256 cycles later, then restart
    sc1.slowclk = 1'b0;
    step(253);
    chk("stop_stalled_255", 32'(sc1.stalled), 32'd0);
    chk("stop_pv_255", 32'(sc1.period_valid), 32'd1);
    step(1);
    chk("stop_stalled_256", 32'(sc1.stalled), 32'd1);
    chk("stop_pv_256", 32'(sc1.period_valid), 32'd0);
    chk("stop_period_kept", 32'(sc1.period), 32'd16);

    sc1.slowclk = 1'b1;
    step(5);
    chk("rs_pre_rise", 32'(sc1.rise), 32'd0);
    chk("rs_pre_stalled", 32'(sc1.stalled), 32'd1);
    step(1);
    chk("rs_rise1", 32'(sc1.rise), 32'd1);
    chk("rs_stalled_clr", 32'(sc1.stalled), 32'd0);
    chk("rs_pv1", 32'(sc1.period_valid), 32'd0);
    step(2);
    sc1.slowclk = 1'b0;
    step(8);
    sc1.slowclk = 1'b1;
    step(5);
    chk("rs_pv_pre2", 32'(sc1.period_valid), 32'd0);
    step(1);
    chk("rs_rise2", 32'(sc1.rise), 32'd1);
    chk("rs_pv2", 32'(sc1.period_valid), 32'd1);
    chk("rs_period2", 32'(sc1.period), 32'd16);

    // Test 3: 3-cycle glitch is rejected, 4-cycle pulse passes
    sc1.slowclk = 1'b0;
    step(20);
    chk("gl_quiet_level", 32'(sc1.level), 32'd0);
    sc1.slowclk = 1'b1;
    for (int unsigned i = 1; i <= 18; i++) begin
      step(1);
      chk("gl3_rise",  32'(sc1.rise), 32'd0);
      chk("gl3_fall",  32'(sc1.fall), 32'd0);
      chk("gl3_level", 32'(sc1.level), 32'd0);
      if (i == 3) sc1.slowclk = 1'b0;
    end
    sc1.slowclk = 1'b1;
    for (int unsigned i = 1; i <= 20; i++) begin
      step(1);
      chk("gl4_rise",  32'(sc1.rise), 32'(i == 6));
      chk("gl4_fall",  32'(sc1.fall), 32'(i == 10));
      chk("gl4_level", 32'(sc1.level), 32'((i >= 6) && (i < 10)));
      if (i == 4) sc1.slowclk = 1'b0;
    end

    // Test 5: asynchronous reset during a high phase, release with input high
    sc1.slowclk = 1'b1;
    step(10);
    chk("mr_level_pre", 32'(sc1.level), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mr_level",   32'(sc1.level), 32'd0);
    chk("mr_rise",    32'(sc1.rise), 32'd0);
    chk("mr_fall",    32'(sc1.fall), 32'd0);
    chk("mr_period",  32'(sc1.period), 32'd0);
    chk("mr_pv",      32'(sc1.period_valid), 32'd0);
    chk("mr_stalled", 32'(sc1.stalled), 32'd0);
    step(3);
    chk("mr_hold_level", 32'(sc1.level), 32'd0);
    reset = 1'b0;
    step(5);
    chk("mr_rise_pre", 32'(sc1.rise), 32'd0);
    chk("mr_level_pre_rise", 32'(sc1.level), 32'd0);
    step(1);
    chk("mr_rise_6", 32'(sc1.rise), 32'd1);
    chk("mr_level_6", 32'(sc1.level), 32'd1);
    chk("mr_pv_first", 32'(sc1.period_valid), 32'd0);
    step(2);
    sc1.slowclk = 1'b0;
    step(8);
    sc1.slowclk = 1'b1;
    step(5);
    chk("mr_pv_pre2", 32'(sc1.period_valid), 32'd0);
    step(1);
    chk("mr_rise2", 32'(sc1.rise), 32'd1);
    chk("mr_pv2", 32'(sc1.period_valid), 32'd1);
    chk("mr_period2", 32'(sc1.period), 32'd16);

    // Test 6: PW=8 instance, 400-cycle period saturates at 255
    for (int unsigned c = 0; c < 410; c++) begin
      sc2.slowclk = ((c % 400) < 200);
      step(1);
      chk("sat_rise", 32'(sc2.rise), 32'((c % 400) == 5));
      chk("sat_stalled", 32'(sc2.stalled), 32'd0);
      if (c == 5) begin
        chk("sat_pv1", 32'(sc2.period_valid), 32'd0);
        chk("sat_period1", 32'(sc2.period), 32'd0);
      end
      if (c == 405) begin
        chk("sat_pv2", 32'(sc2.period_valid), 32'd1);
        chk("sat_period2", 32'(sc2.period), 32'd255);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
